// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter serialising byte reads/writes onto one single-port RAM.
// Define ARB_FIXED_PRIO_EN for strict A-over-B priority; default is round-robin.
module ram_arbiter_2p #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  state_t state;
  logic   rd_owner_b;
  logic   pick_b;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_b = b_req & ~a_req;
`else
  logic last_gnt_b;
  // On a tie the port that did not win last time goes next.
  assign pick_b = b_req & (~a_req | ~last_gnt_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_owner_b <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_b <= 1'b1;
`endif
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      ram_cs     <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            a_gnt      <= ~pick_b;
            b_gnt      <= pick_b;
            ram_cs     <= 1'b1;
            ram_rw     <= pick_b ? b_rw    : a_rw;
            ram_addr   <= pick_b ? b_addr  : a_addr;
            ram_din    <= pick_b ? b_wdata : a_wdata;
            rd_owner_b <= pick_b;
`ifndef ARB_FIXED_PRIO_EN
            last_gnt_b <= pick_b;
`endif
            busy       <= 1'b1;
            state      <= ACCESS;
          end else begin
            ram_cs <= 1'b0;
          end
        end
        ACCESS: begin
          ram_cs <= 1'b0;
          if (ram_rw) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_owner_b) begin
            b_rdata  <= ram_dout;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= ram_dout;
            a_rvalid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_cs <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 64x8 registered-read RAM.
module tb_ram_arbiter_2p;

  logic       clk, rst;
  logic       a_req, a_rw, b_req, b_rw;
  logic [5:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_cs, ram_rw, busy;

  logic [7:0] mem [0:63];
  int total = 0;
  int bad   = 0;

  ram_arbiter_2p #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rw) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic rw, input logic [5:0] addr, input logic [7:0] wd);
    a_req = req; a_rw = rw; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic rw, input logic [5:0] addr, input logic [7:0] wd);
    b_req = req; b_rw = rw; b_addr = addr; b_wdata = wd;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  logic exp_a;

  initial begin
    drive_a(0, 0, 6'h00, 8'h00);
    drive_b(0, 0, 6'h00, 8'h00);
    rst = 1'b1;
    step;
    check("rst_busy", busy, 0);
    check("rst_cs", ram_cs, 0);
    check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
    step;
    rst = 1'b0;

    // 1: A write then A read of 0x05
    drive_a(1, 1, 6'h05, 8'hA5);
    check("t1_idle_busy", busy, 0);
    step;
    check("t1_w_gnt", {a_gnt, b_gnt}, 2'b10);
    check("t1_w_ram", {ram_cs, ram_rw, ram_addr, ram_din}, {1'b1, 1'b1, 6'h05, 8'hA5});
    check("t1_w_busy", busy, 1);
    drive_a(0, 0, 6'h00, 8'h00);
    step;
    check("t1_w_done", {a_gnt, ram_cs, busy}, 3'b000);
    check("t1_mem5", mem[5], 8'hA5);
    drive_a(1, 0, 6'h05, 8'h00);
    step;
    check("t1_r_gnt", {a_gnt, ram_cs, ram_rw, busy}, 4'b1101);
    drive_a(0, 0, 6'h00, 8'h00);
    step;
    check("t1_r_wait", {a_gnt, a_rvalid, busy}, 3'b001);
    step;
    check("t1_r_valid", {a_rvalid, b_rvalid, busy}, 3'b100);
    check("t1_rdata", a_rdata, 8'hA5);
    step;
    check("t1_rvalid_pulse", a_rvalid, 0);
    check("t1_rdata_hold", a_rdata, 8'hA5);

    // 4: A writes 0x3F, B read of 0x3F arrives during A's access
    drive_a(1, 1, 6'h3F, 8'h7E);
    step;
    check("t4_a_gnt", {a_gnt, b_gnt}, 2'b10);
    drive_a(0, 0, 6'h00, 8'h00);
    drive_b(1, 0, 6'h3F, 8'h00);
    step;
    check("t4_b_ignored", {b_gnt, busy}, 2'b00);
    check("t4_mem3f", mem[63], 8'h7E);
    step;
    check("t4_b_gnt", {a_gnt, b_gnt}, 2'b01);
    drive_b(0, 0, 6'h00, 8'h00);
    step;
    step;
    check("t4_b_valid", {a_rvalid, b_rvalid}, 2'b01);
    check("t4_b_rdata", b_rdata, 8'h7E);
    check("t4_a_rdata_kept", a_rdata, 8'hA5);

    // 2: preload, reset, then simultaneous reads
    drive_a(1, 1, 6'h00, 8'h11);
    step;
    drive_a(0, 0, 6'h00, 8'h00);
    step;
    drive_b(1, 1, 6'h3F, 8'h22);
    step;
    drive_b(0, 0, 6'h00, 8'h00);
    step;
    check("t2_preload", {mem[0], mem[63]}, 16'h1122);
    do_reset;
    drive_a(1, 0, 6'h00, 8'h00);
    drive_b(1, 0, 6'h3F, 8'h00);
    step;
    check("t2_first_gnt", {a_gnt, b_gnt}, 2'b10);
    drive_a(0, 0, 6'h00, 8'h00);
    step;
    step;
    check("t2_a_valid", {a_rvalid, b_rvalid, b_gnt}, 3'b100);
    check("t2_a_rdata", a_rdata, 8'h11);
    step;
    check("t2_second_gnt", {a_gnt, b_gnt}, 2'b01);
    drive_b(0, 0, 6'h00, 8'h00);
    step;
    step;
    check("t2_b_valid", {a_rvalid, b_rvalid}, 2'b01);
    check("t2_rdata", {a_rdata, b_rdata}, 16'h1122);

    // 3: both hold write requests across four grants
    do_reset;
    drive_a(1, 1, 6'h01, 8'hAA);
    drive_b(1, 1, 6'h02, 8'hBB);
    for (int g = 0; g < 4; g++) begin
      step;
`ifdef ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (g % 2 == 0);
`endif
      check($sformatf("t3_grant%0d", g), {a_gnt, b_gnt}, {exp_a, ~exp_a});
      step;
      check($sformatf("t3_gap%0d", g), {a_gnt, b_gnt, busy}, 3'b000);
    end
    drive_a(0, 0, 6'h00, 8'h00);
    drive_b(0, 0, 6'h00, 8'h00);
    step;
    step;

    // 5: reset during RD_WAIT of an A read
    drive_a(1, 0, 6'h05, 8'h00);
    step;
    check("t5_gnt", a_gnt, 1);
    drive_a(0, 0, 6'h00, 8'h00);
    step;
    check("t5_rd_wait", {busy, a_rvalid}, 2'b10);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("t5_after_rst", {busy, ram_cs, a_gnt, b_gnt, a_rvalid, b_rvalid}, 6'b000000);
    check("t5_rdata_clr", a_rdata, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step;
      check($sformatf("t5_no_rvalid%0d", k), a_rvalid, 0);
    end

    // 6: idle cycles
    for (int k = 0; k < 10; k++) begin
      step;
      check($sformatf("t6_idle%0d", k), {ram_cs, busy}, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
